multicycle_controller: RTL and testbench

Sequencing control unit for the multi-cycle RV32I datapath; it drives the ALU's ALUControl input and consumes the ALU's Zero flag. From the fetched instruction fields it steps a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it issues the datapath mux selects and write enables. It covers the base ALU ops, loads/stores, all six conditional branches, jal, and the Zba/Zbb subset the ALU implements.

---
 rtl/rv_ctrl_pkg.sv | 88 ++++++++
 rtl/multicycle_controller_if.sv | 42 ++++
 rtl/multicycle_controller_alu_decoder.sv | 72 +++++++
 rtl/multicycle_controller.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared encodings for the multi-cycle RV32I control unit:
//   - ALUControl codes understood by the ALU
//   - opcode constants for the supported instruction classes
//   - FSM state codes (plain constants so legacy code can compare against them)
//   - mux-select encodings for ALUSrcA / ALUSrcB / ResultSrc / ImmSrc
//   - imm_src_of(): immediate format selected purely from the opcode
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

    // ALUControl codes
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_ANDN   = 4'b1010;
    localparam logic [3:0] ALU_ORN    = 4'b1011;
    localparam logic [3:0] ALU_XNOR   = 4'b1100;
    localparam logic [3:0] ALU_SH1ADD = 4'b1101;
    localparam logic [3:0] ALU_SH2ADD = 4'b1110;
    localparam logic [3:0] ALU_SH3ADD = 4'b1111;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // R-type funct7 groups
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_SHAD = 7'b0010000;

    // FSM state codes
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ImmSrc
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    // Immediate format depends only on the opcode; unsupported opcodes get I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the control unit and the multi-cycle datapath.
//   Datapath -> controller : op, funct3, funct7 (instruction fields), Zero
//   Controller -> datapath : PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//                            ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl,
//                            Illegal
// modport master : the controller
// modport slave  : the datapath
// -----------------------------------------------------------------------------
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl, Illegal
    );

    modport slave (
        output op, funct3, funct7, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl, Illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU-operation decode for register (op[5]=1) and immediate
// (op[5]=0) arithmetic instructions.
//   op5        in  1  instr[5]: 1 = R-type, 0 = I-type
//   funct3     in  3  instr[14:12]
//   funct7     in  7  instr[31:25]
//   ALUControl out 4  ALU operation code
//   illegal    out 1  R-type funct7/funct3 pair outside the supported set
// -----------------------------------------------------------------------------
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] ALUControl,
    output logic       illegal
);

    // Base RV32I mapping shared by R-type (funct7=0) and most I-type ops.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        if (op5) begin
            case (funct7)
                F7_BASE: ALUControl = base_op(funct3);
                F7_ALT: begin
                    case (funct3)
                        3'b000:  ALUControl = ALU_SUB;
                        3'b101:  ALUControl = ALU_SRA;
                        3'b111:  ALUControl = ALU_ANDN;
                        3'b110:  ALUControl = ALU_ORN;
                        3'b100:  ALUControl = ALU_XNOR;
                        default: illegal    = 1'b1;
                    endcase
                end
                F7_SHAD: begin
                    case (funct3)
                        3'b010:  ALUControl = ALU_SH1ADD;
                        3'b100:  ALUControl = ALU_SH2ADD;
                        3'b110:  ALUControl = ALU_SH3ADD;
                        default: illegal    = 1'b1;
                    endcase
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            // No subi: funct3=000 is always add. funct7[5] only picks srai.
            if (funct3 == 3'b101 && funct7[5])
                ALUControl = ALU_SRA;
            else
                ALUControl = base_op(funct3);
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore sequencing FSM for the multi-cycle RV32I datapath. Walks each
// instruction through FETCH / DECODE / execute / memory / writeback and issues
// the datapath mux selects and write enables for the current state.
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous, active-high; forces FETCH
//   bus    master modport of multicycle_controller_if
//          (op/funct3/funct7/Zero in; all control selects/enables out)
// -----------------------------------------------------------------------------
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    state_t     state;
    state_t     state_next;
    state_t     decode_target;
    logic       decode_illegal;

    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic [3:0] branch_alu;
    logic       branch_taken;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [3:0] alu_control;

    alu_decoder u_alu_decoder (
        .op5        (bus.op[5]),
        .funct3     (bus.funct3),
        .funct7     (bus.funct7),
        .ALUControl (dec_alu),
        .illegal    (dec_illegal)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples
    // its inputs before any of them update on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    // Opcode dispatch out of DECODE, plus the illegal-encoding check. Branch
    // funct3 010/011 has no comparison and is rejected here so BRANCH never
    // sees it.
    always_comb begin
        decode_target  = S_FETCH;
        decode_illegal = 1'b0;
        case (bus.op)
            OP_LOAD, OP_STORE: decode_target = S_MEMADR;
            OP_RTYPE: begin
                decode_target  = S_EXECUTER;
                decode_illegal = dec_illegal;
            end
            OP_ITYPE:  decode_target = S_EXECUTEI;
            OP_BRANCH: begin
                decode_target  = S_BRANCH;
                decode_illegal = (bus.funct3[2:1] == 2'b01);
            end
            OP_JAL:    decode_target = S_JAL;
            default:   decode_illegal = 1'b1;
        endcase
        if (decode_illegal)
            decode_target = S_FETCH;
    end

    // Branch compare: the ALU subtracts or compares, and Zero from that same
    // cycle decides whether the target held in ALUOut is loaded into the PC.
    // slt/sltu yield 0 when the "less than" is false, hence Zero => not less.
    always_comb begin
        branch_alu   = ALU_SUB;
        branch_taken = 1'b0;
        case (bus.funct3)
            3'b000: begin branch_alu = ALU_SUB;  branch_taken =  bus.Zero; end
            3'b001: begin branch_alu = ALU_SUB;  branch_taken = !bus.Zero; end
            3'b100: begin branch_alu = ALU_SLT;  branch_taken = !bus.Zero; end
            3'b101: begin branch_alu = ALU_SLT;  branch_taken =  bus.Zero; end
            3'b110: begin branch_alu = ALU_SLTU; branch_taken = !bus.Zero; end
            3'b111: begin branch_alu = ALU_SLTU; branch_taken =  bus.Zero; end
            default: ;
        endcase
    end

    // Next state and per-state outputs. Anything not set below stays 0/add.
    always_comb begin
        state_next  = S_FETCH;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        reg_write   = 1'b0;
        alu_control = ALU_ADD;

        case (state)
            S_FETCH: begin
                // Read instruction at PC, latch IR/OldPC, and PC <= PC + 4.
                ir_write   = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form OldPC + imm for branch/jal targets.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                state_next = decode_target;
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                // op[5] separates store (0100011) from load (0000011).
                state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = dec_alu;
                state_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = dec_alu;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                result_src  = RES_ALUOUT;
                alu_control = branch_alu;
                pc_write    = branch_taken;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                // PC <= target from ALUOut while the ALU forms OldPC + 4,
                // which ALUWB then writes to rd.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Write enables are masked by reset directly: the state register is
    // already FETCH during reset, whose Moore outputs would otherwise assert
    // PCWrite/IRWrite while the datapath is being held.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src_of(bus.op);
    assign bus.Illegal    = (state == S_DECODE) && decode_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Scoreboard bench: each scenario pushes the expected per-cycle control vector
// for the instruction it drives, then pops one entry per DUT cycle and
// compares. Vector layout:
//   {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUSrcA[1:0],
//    ALUSrcB[1:0], RegWrite, ImmSrc[2:0], ALUControl[3:0], Illegal}
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic clk;
    logic reset;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [18:0] vec;
    } exp_t;

    typedef struct packed {
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] alu;
    } alu_case_t;

    typedef struct packed {
        logic [2:0] f3;
        logic       zero;
        logic [3:0] alu;
        logic       taken;
    } br_case_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] imm;
    } ill_case_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [18:0] ev(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb_, input logic rw,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb_, rw, imm, alu, ill};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ImmSrc,
                bus.ALUControl, bus.Illegal};
    endfunction

    task automatic push(input string name, input logic [18:0] vec);
        exp_t e;
        e.name = name;
        e.vec  = vec;
        sb.push_back(e);
    endtask

    task automatic push_fetch(input string name, input logic [2:0] imm);
        push({name, ".fetch"}, ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, imm, 4'b0000, 0));
    endtask

    task automatic push_decode(input string name, input logic [2:0] imm, input logic ill);
        push({name, ".decode"}, ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, imm, 4'b0000, ill));
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z);
        bus.op     = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.Zero   = z;
    endtask

    // Reset state, then the first FETCH after release.
    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000000, 1'b0);
        push("reset.hold", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b000, 4'b0000, 0));
        push_fetch("reset.release", 3'b000);
        #1;
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e.vec) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e.vec) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
    endtask

    // add x3,x1,x2 (0x002081B3): funct7=0, rs2=2, rs1=1, funct3=0, rd=3.
    task automatic test_add();
        exp_t        e;
        logic [31:0] instr;
        instr = 32'h002081B3;
        drive(instr[6:0], instr[14:12], instr[31:25], 1'b0);
        push_fetch("add", 3'b000);
        push_decode("add", 3'b000, 1'b0);
        push("add.executer", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b000, 4'b0000, 0));
        push("add.aluwb",    ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 4'b0000, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
            end
        end
        @(negedge clk);
    endtask

    // R-type and I-type ALU decode, including Zba/Zbb and srai / no-subi.
    task automatic test_alu_ops();
        exp_t      e;
        alu_case_t rt [6];
        alu_case_t it [4];
        rt = '{'{7'b0010000, 3'b100, 4'b1110},   // sh2add
               '{7'b0100000, 3'b000, 4'b0001},   // sub
               '{7'b0100000, 3'b101, 4'b0111},   // sra
               '{7'b0100000, 3'b100, 4'b1100},   // xnor
               '{7'b0010000, 3'b110, 4'b1111},   // sh3add
               '{7'b0000000, 3'b011, 4'b0100}};  // sltu
        it = '{'{7'b0100000, 3'b101, 4'b0111},   // srai
               '{7'b0100000, 3'b000, 4'b0000},   // addi with funct7[5] set: still add
               '{7'b0000000, 3'b101, 4'b0110},   // srli
               '{7'b0000000, 3'b111, 4'b1001}};  // andi
        for (int k = 0; k < 10; k++) begin
            logic       is_r;
            alu_case_t  c;
            is_r = (k < 6);
            c    = is_r ? rt[k] : it[k-6];
            drive(is_r ? 7'b0110011 : 7'b0010011, c.f3, c.f7, 1'b0);
            push_fetch($sformatf("alu%0d", k), 3'b000);
            push_decode($sformatf("alu%0d", k), 3'b000, 1'b0);
            push($sformatf("alu%0d.execute", k),
                 ev(0, 0, 0, 0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01, 0, 3'b000, c.alu, 0));
            push($sformatf("alu%0d.aluwb", k),
                 ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 4'b0000, 0));
            for (int i = 0; sb.size() > 0; i++) begin
                if (i > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.vec) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
                end
            end
            @(negedge clk);
        end
    endtask

    // Conditional branches: compare op and taken decision from Zero; 3 cycles.
    task automatic test_branch();
        exp_t     e;
        br_case_t bt [7];
        bt = '{'{3'b001, 1'b0, 4'b0001, 1'b1},   // bne,  Zero=0 -> taken
               '{3'b111, 1'b0, 4'b0100, 1'b0},   // bgeu, Zero=0 -> not taken
               '{3'b000, 1'b1, 4'b0001, 1'b1},   // beq,  Zero=1 -> taken
               '{3'b000, 1'b0, 4'b0001, 1'b0},   // beq,  Zero=0 -> not taken
               '{3'b100, 1'b1, 4'b0011, 1'b0},   // blt,  Zero=1 -> not taken
               '{3'b101, 1'b1, 4'b0011, 1'b1},   // bge,  Zero=1 -> taken
               '{3'b110, 1'b0, 4'b0100, 1'b1}};  // bltu, Zero=0 -> taken
        foreach (bt[k]) begin
            drive(7'b1100011, bt[k].f3, 7'b0000000, bt[k].zero);
            push_fetch($sformatf("br%0d", k), 3'b010);
            push_decode($sformatf("br%0d", k), 3'b010, 1'b0);
            push($sformatf("br%0d.branch", k),
                 ev(bt[k].taken, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b010, bt[k].alu, 0));
            for (int i = 0; sb.size() > 0; i++) begin
                if (i > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.vec) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
                end
            end
            @(negedge clk);
        end
    endtask

    // lw (5 cycles) then sw (4 cycles, one MemWrite cycle).
    task automatic test_memory();
        exp_t e;
        drive(7'b0000011, 3'b010, 7'b0000000, 1'b0);
        push_fetch("lw", 3'b000);
        push_decode("lw", 3'b000, 1'b0);
        push("lw.memadr",  ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 4'b0000, 0));
        push("lw.memread", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 4'b0000, 0));
        push("lw.memwb",   ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 4'b0000, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
            end
        end
        @(negedge clk);
        drive(7'b0100011, 3'b010, 7'b0000000, 1'b0);
        push_fetch("sw", 3'b001);
        push_decode("sw", 3'b001, 1'b0);
        push("sw.memadr",   ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b001, 4'b0000, 0));
        push("sw.memwrite", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b001, 4'b0000, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
            end
        end
        @(negedge clk);
    endtask

    // jal: JAL loads PC, then ALUWB writes the link value.
    task automatic test_jal();
        exp_t e;
        drive(7'b1101111, 3'b000, 7'b0000000, 1'b0);
        push_fetch("jal", 3'b011);
        push_decode("jal", 3'b011, 1'b0);
        push("jal.jal",   ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b011, 4'b0000, 0));
        push("jal.aluwb", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b011, 4'b0000, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
            end
        end
        @(negedge clk);
    endtask

    // Unsupported encodings: Illegal in DECODE only, back to FETCH after 2 cycles.
    task automatic test_illegal();
        exp_t      e;
        ill_case_t lt [4];
        lt = '{'{7'b0110111, 3'b000, 7'b0000000, 3'b000},   // lui
               '{7'b0110011, 3'b001, 7'b0100000, 3'b000},   // R-type alt funct7, funct3=001
               '{7'b0110011, 3'b000, 7'b0000001, 3'b000},   // mul encoding, funct7=0000001
               '{7'b1100011, 3'b010, 7'b0000000, 3'b010}};  // branch funct3=010
        foreach (lt[k]) begin
            drive(lt[k].op, lt[k].f3, lt[k].f7, 1'b0);
            push_fetch($sformatf("ill%0d", k), lt[k].imm);
            push_decode($sformatf("ill%0d", k), lt[k].imm, 1'b1);
            for (int i = 0; sb.size() > 0; i++) begin
                if (i > 0) @(negedge clk);
                #1;
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.vec) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
                end
            end
            @(negedge clk);
        end
    endtask

    // sw in flight: reset in MEMWRITE kills MemWrite at once and returns to FETCH.
    task automatic test_reset_mid_store();
        exp_t e;
        drive(7'b0100011, 3'b010, 7'b0000000, 1'b0);
        push_fetch("rst_sw", 3'b001);
        push_decode("rst_sw", 3'b001, 1'b0);
        push("rst_sw.memadr",   ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b001, 4'b0000, 0));
        push("rst_sw.memwrite", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b001, 4'b0000, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
            end
        end
        // Still inside the MEMWRITE cycle.
        push("rst_sw.assert",  ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b001, 4'b0000, 0));
        push("rst_sw.held",    ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b001, 4'b0000, 0));
        push_fetch("rst_sw.release", 3'b001);
        #1;
        reset = 1'b1;
        #1;
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e.vec) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e.vec) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
        reset = 1'b0;
        #1;
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e.vec) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
    endtask

    // Back-to-back after reset: xor then the FETCH that must follow ALUWB.
    task automatic test_back_to_back();
        exp_t e;
        drive(7'b0110011, 3'b100, 7'b0000000, 1'b0);
        push_fetch("b2b_xor", 3'b000);
        push_decode("b2b_xor", 3'b000, 1'b0);
        push("b2b_xor.executer", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b000, 4'b0101, 0));
        push("b2b_xor.aluwb",    ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 4'b0000, 0));
        push_fetch("b2b_next", 3'b000);
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(7'b0000000, 3'b000, 7'b0000000, 1'b0);
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_memory();
        test_jal();
        test_illegal();
        test_add();
        test_reset_mid_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
